// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer.
//
// Fetches sequential instruction words from a combinational-read instruction
// memory into a small circular buffer and presents the oldest entry to the
// decode stage. A redirect flushes the buffer and restarts fetching at the
// word-aligned redirect target.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   imem_addr      fetch address to instruction memory (equals fetch_pc)
//   imem_rdata     instruction word at imem_addr, same cycle
//   redirect_valid flush the buffer and refetch from redirect_pc
//   redirect_pc    redirect target (low two bits ignored)
//   dec_ready      decode accepts the head entry this cycle
//   dec_valid      head entry valid
//   dec_inst       head instruction (zero when dec_valid is low)
//   dec_pc         head instruction address (zero when dec_valid is low)
//   buf_count      current occupancy, 0..DEPTH

module inst_prefetch_buffer #(
  parameter int unsigned                PC_Width        = 32,
  parameter int unsigned                Inst_Data_width = 32,
  parameter int unsigned                DEPTH           = 4,
  parameter logic [PC_Width-1:0]        RESET_PC        = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [PC_Width-1:0]           imem_addr,
  input  logic [Inst_Data_width-1:0]    imem_rdata,
  input  logic                          redirect_valid,
  input  logic [PC_Width-1:0]           redirect_pc,
  input  logic                          dec_ready,
  output logic                          dec_valid,
  output logic [Inst_Data_width-1:0]    dec_inst,
  output logic [PC_Width-1:0]           dec_pc,
  output logic [$clog2(DEPTH):0]        buf_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0]     DepthC  = CntW'(DEPTH);
  localparam logic [PC_Width-1:0] PcStep  = PC_Width'(4);

  // Architectural state
  logic [PC_Width-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  // Entry storage; no reset needed since count_q gates every read.
  logic [PC_Width-1:0]        pc_mem   [DEPTH];
  logic [Inst_Data_width-1:0] inst_mem [DEPTH];

  logic pop;
  logic push;
  logic not_full;

  // Outputs depend only on registered state, so dec_ready and
  // redirect_valid never reach the decode-side outputs combinationally.
  always_comb begin
    dec_valid = (count_q != '0);
    dec_pc    = '0;
    dec_inst  = '0;
    if (dec_valid) begin
      dec_pc   = pc_mem[rd_ptr_q];
      dec_inst = inst_mem[rd_ptr_q];
    end
  end

  assign imem_addr = fetch_pc_q;
  assign buf_count = count_q;

  assign not_full = (count_q < DepthC);
  assign pop      = dec_valid & dec_ready;
  // A full buffer may still accept a word when the head leaves this cycle.
  assign push     = ~redirect_valid & (not_full | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      // Flush wins over any pop or push in the same cycle.
      fetch_pc_d = {redirect_pc[PC_Width-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + PcStep;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer. Instruction memory holds word
// 0x1000_0000 + k at byte address 4k. Directed scenarios drive the DUT and
// check occupancy/addresses directly; every entry handed to decode is
// checked by a negedge monitor against a queue of expected entries.

module tb_inst_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [2:0]  buf_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  inst_prefetch_buffer #(
    .PC_Width       (32),
    .Inst_Data_width(32),
    .DEPTH          (4),
    .RESET_PC       (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_ready     (dec_ready),
    .dec_valid     (dec_valid),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .buf_count     (buf_count)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  // Posedges at 5, 15, 25 ...; negedges at 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_pop(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = imem_word(pc);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Scoreboard monitor: an entry leaves at the next edge when valid and
  // ready are both high, unless a redirect or reset discards it.
  always @(negedge clk) begin
    if (rst && dec_valid && dec_ready && !redirect_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pop: got pc 0x%08h, want no pop", dec_pc);
      end else begin
        mon_e = sb.pop_front();
        if (dec_pc !== mon_e.pc || dec_inst !== mon_e.inst) begin
          fails++;
          $display("FAIL pop_entry: got pc 0x%08h inst 0x%08h, want pc 0x%08h inst 0x%08h",
                   dec_pc, dec_inst, mon_e.pc, mon_e.inst);
        end
      end
    end
  end

  int cnt_exp [6] = '{1, 2, 3, 4, 4, 4};

  initial begin
    rst            = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    check("rst_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_count", {29'd0, buf_count}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", dec_pc, 32'h0);
    check("rst_inst", dec_inst, 32'h0);
    step();
    rst = 1'b1;

    // Streaming with decode always ready: one entry in flight.
    dec_ready = 1'b1;
    expect_pop(32'h0);
    expect_pop(32'h4);
    expect_pop(32'h8);
    expect_pop(32'hC);
    for (int k = 0; k < 5; k++) begin
      step();
      check("stream_pc", dec_pc, 32'(4 * k));
      check("stream_count", {29'd0, buf_count}, 32'd1);
    end
    dec_ready = 1'b0;

    // Stall fills the buffer, then one pop with a concurrent push.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      check("fill_count", {29'd0, buf_count}, 32'(cnt_exp[k]));
    end
    check("fill_addr", imem_addr, 32'h10);
    check("fill_pc", dec_pc, 32'h0);
    expect_pop(32'h0);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("full_pop_count", {29'd0, buf_count}, 32'd4);
    check("full_pop_pc", dec_pc, 32'h4);
    check("full_pop_addr", imem_addr, 32'h14);
    expect_pop(32'h4);
    expect_pop(32'h8);
    expect_pop(32'hC);
    expect_pop(32'h10);
    dec_ready = 1'b1;
    repeat (4) step();
    dec_ready = 1'b0;
    check("drain_pc", dec_pc, 32'h14);
    check("drain_count", {29'd0, buf_count}, 32'd4);

    // Redirect with three entries buffered, unaligned target.
    do_reset();
    repeat (3) step();
    check("pre_redir_count", {29'd0, buf_count}, 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    check("redir_count", {29'd0, buf_count}, 32'd0);
    check("redir_valid", {31'd0, dec_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_pc_zero", dec_pc, 32'h0);
    check("redir_inst_zero", dec_inst, 32'h0);
    step();
    check("redir_head_valid", {31'd0, dec_valid}, 32'd1);
    check("redir_head_pc", dec_pc, 32'h100);
    check("redir_head_inst", dec_inst, 32'h1000_0040);
    expect_pop(32'h100);
    expect_pop(32'h104);
    dec_ready = 1'b1;
    repeat (2) step();
    dec_ready = 1'b0;
    check("post_redir_pc", dec_pc, 32'h108);
    check("post_redir_count", {29'd0, buf_count}, 32'd1);

    // Redirect and ready together on a full buffer: redirect wins.
    do_reset();
    repeat (4) step();
    check("full_count", {29'd0, buf_count}, 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    dec_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("redir_rdy_count", {29'd0, buf_count}, 32'd0);
    check("redir_rdy_valid", {31'd0, dec_valid}, 32'd0);
    check("redir_rdy_addr", imem_addr, 32'h200);
    expect_pop(32'h200);
    step();
    check("redir_rdy_pc", dec_pc, 32'h200);
    check("redir_rdy_cnt1", {29'd0, buf_count}, 32'd1);
    step();
    dec_ready = 1'b0;
    check("redir_rdy_next", dec_pc, 32'h204);

    // Fetch address wraps past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("wrap_count0", {29'd0, buf_count}, 32'd0);
    step();
    check("wrap_pc", dec_pc, 32'hFFFF_FFFC);
    check("wrap_inst", dec_inst, 32'h4FFF_FFFF);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset asserted between edges while streaming.
    do_reset();
    dec_ready = 1'b1;
    expect_pop(32'h0);
    expect_pop(32'h4);
    repeat (3) step();
    #2;
    rst       = 1'b0;
    dec_ready = 1'b0;
    #1;
    check("async_valid", {31'd0, dec_valid}, 32'd0);
    check("async_count", {29'd0, buf_count}, 32'd0);
    check("async_addr", imem_addr, 32'h0);
    check("async_pc", dec_pc, 32'h0);
    check("async_inst", dec_inst, 32'h0);
    step();
    rst = 1'b1;
    step();
    check("restart_pc", dec_pc, 32'h0);
    check("restart_count", {29'd0, buf_count}, 32'd1);

    check("sb_left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
